// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b - bin), LSB-first; done pulses WIDTH cycles after start acceptance.
// Backpressure: start is taken only while ready=1; start during busy is ignored and the last result is held.
module serial_sub #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic [WIDTH-1:0] res_nxt;
   logic             brw;
   logic [CNT_W-1:0] cnt;

   logic             d_bit;
   logic             brw_nxt;

   // full-subtractor cell on the current LSBs
   assign d_bit   = a_sr[0] ^ b_sr[0] ^ brw;
   assign brw_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
   assign res_nxt = {d_bit, res_sr[WIDTH-1:1]};

   assign ready = (state == IDLE) || (state == DONE);
   assign busy  = (state == RUN);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            // DONE lasts a single cycle; a start here is a back-to-back acceptance
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= last;
         if (load) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= bin;
            cnt  <= '0;
         end else if (step) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            brw    <= brw_nxt;
            res_sr <= res_nxt;
            cnt    <= cnt + CNT_ONE;
         end
         // the final bit goes straight into diff so it is valid alongside done
         if (last) begin
            diff <= res_nxt;
            bout <= brw_nxt;
         end
      end
   end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: driver pushes hand-computed results, monitor pops on done.
module tb_serial_sub;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;

   serial_sub #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             bo;
      int               acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // monitor: every done pulse must match the oldest outstanding request
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("done_unexpected", 32'(done), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("diff", 32'(diff), 32'(mon_e.d));
            chk("bout", 32'(bout), 32'(mon_e.bo));
            chk("latency", 32'(cyc - mon_e.acc), 32'(WIDTH));
            chk("ready_in_done", 32'(ready), 32'd1);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) chk("ready_timeout", 32'(ready), 32'd1);
   endtask

   task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ibin,
                        input logic [WIDTH-1:0] ed, input logic eb);
      wait_ready();
      a     = ia;
      b     = ib;
      bin   = ibin;
      start = 1'b1;
      sb.push_back('{d: ed, bo: eb, acc: cyc + 1});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int bc;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_done",  32'(done),  32'd0);
      chk("rst_diff",  32'(diff),  32'd0);
      chk("rst_bout",  32'(bout),  32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // basic op with busy-window measurement
      issue(8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
      bc = 0;
      repeat (WIDTH) begin
         if (busy === 1'b1) bc++;
         @(negedge clk);
      end
      chk("busy_cycles", 32'(bc), 32'(WIDTH));
      chk("ready_at_done", 32'(ready), 32'd1);
      chk("busy_at_done",  32'(busy),  32'd0);
      @(negedge clk);
      chk("done_dropped",  32'(done),  32'd0);
      chk("ready_after",   32'(ready), 32'd1);

      issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
      issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      issue(8'hA5, 8'h00, 1'b0, 8'hA5, 1'b0);
      wait_drain();
      repeat (2) @(negedge clk);

      // start during RUN cycles 3-5 must be ignored; old result held meanwhile
      issue(8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
      @(negedge clk);
      start = 1'b1;
      a     = 8'h01;
      b     = 8'h01;
      repeat (3) begin
         chk("hold_diff", 32'(diff), 32'hA5);
         chk("hold_bout", 32'(bout), 32'd0);
         chk("hold_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      start = 1'b0;
      wait_drain();
      repeat (12) @(negedge clk);

      // back-to-back: start held through the DONE cycle
      wait_ready();
      a     = 8'h09;
      b     = 8'h04;
      bin   = 1'b0;
      start = 1'b1;
      sb.push_back('{d: 8'h05, bo: 1'b0, acc: cyc + 1});
      repeat (WIDTH + 1) @(negedge clk);
      chk("b2b_ready", 32'(ready), 32'd1);
      a = 8'h04;
      b = 8'h09;
      sb.push_back('{d: 8'hFB, bo: 1'b1, acc: cyc + 1});
      @(negedge clk);
      start = 1'b0;
      wait_drain();
      repeat (2) @(negedge clk);

      // reset during RUN cycle 4 aborts with no done pulse
      wait_ready();
      a     = 8'h33;
      b     = 8'h11;
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort_diff",  32'(diff),  32'd0);
      chk("abort_bout",  32'(bout),  32'd0);
      chk("abort_busy",  32'(busy),  32'd0);
      chk("abort_ready", 32'(ready), 32'd1);
      chk("abort_done",  32'(done),  32'd0);
      repeat (12) @(negedge clk);

      issue(8'h80, 8'h7F, 1'b0, 8'h01, 1'b0);
      issue(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
      wait_drain();
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
